// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   state_e  - FSM state encoding (RUN=0, LOAD=1, BRANCH=2, WAIT=3)
//   REG_ZERO - hard-wired zero register index, never a hazard source
//   CNT_W    - stretch counter width
//   MAX_CYCLES - largest legal stall/flush length
package hazard_pkg;
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_BRANCH = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;
    localparam int REG_ZERO   = 0;
    localparam int MAX_CYCLES = 8;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
endpackage

// File: rtl/hazard_load_use_detect.sv
// hazard_load_use_detect: combinational load-use hazard comparator.
//   in : ex_mem_read, ex_rd, id_rs, id_rt, id_uses_rt
//   out: lu - ID instruction needs the result of the load currently in EX
module hazard_load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             lu
);
    assign lu = ex_mem_read && ex_rd != REG_W'(REG_ZERO) &&
                (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline hazard controller feeding the 3-input ID/EX flush OR gate.
//   in : clk, rst (sync, active-high), id_rs, id_rt, id_uses_rt, ex_rd,
//        ex_mem_read, ex_branch_taken, mem_busy
//   out: pc_write, ifid_write, bubble_load, flush_branch, bubble_wait, state_o
//   HAZARD_PERF_CNT_EN adds saturating 32-bit request counters
//        perf_load_cnt, perf_branch_cnt, perf_wait_cnt.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W               = 5,
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             bubble_load,
    output logic             flush_branch,
    output logic             bubble_wait,
    output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      perf_load_cnt,
    output logic [31:0]      perf_branch_cnt,
    output logic [31:0]      perf_wait_cnt
`endif
);
    localparam logic [CNT_W-1:0] LOAD_RELOAD =
        CNT_W'(LOAD_STALL_CYCLES > 1 ? LOAD_STALL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] BRANCH_RELOAD =
        CNT_W'(BRANCH_FLUSH_CYCLES > 1 ? BRANCH_FLUSH_CYCLES - 2 : 0);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;
    hazard_load_use_detect #(.REG_W(REG_W)) u_lu (
        .ex_mem_read(ex_mem_read),
        .ex_rd      (ex_rd),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .lu         (lu)
    );
    // mem_busy wins in every state and always lands in WAIT; WAIT with
    // mem_busy low falls through to the RUN decision in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        bubble_load  = 1'b0;
        flush_branch = 1'b0;
        bubble_wait  = 1'b0;
        if (mem_busy) begin
            {pc_write, ifid_write, bubble_wait} = 3'b001;
            state_d = ST_WAIT;
        end else if (state_q == ST_LOAD) begin
            // EX holds a bubble here, so a taken branch cannot be real
            {pc_write, ifid_write, bubble_load} = 3'b001;
            state_d = cnt_q == '0 ? ST_RUN : ST_LOAD;
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        end else if (state_q == ST_BRANCH && !ex_branch_taken) begin
            flush_branch = 1'b1;
            state_d = cnt_q == '0 ? ST_RUN : ST_BRANCH;
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        end else if (ex_branch_taken) begin
            flush_branch = 1'b1;
            state_d = BRANCH_FLUSH_CYCLES > 1 ? ST_BRANCH : ST_RUN;
            cnt_d   = BRANCH_FLUSH_CYCLES > 1 ? BRANCH_RELOAD : cnt_q;
        end else if (lu) begin
            {pc_write, ifid_write, bubble_load} = 3'b001;
            state_d = LOAD_STALL_CYCLES > 1 ? ST_LOAD : ST_RUN;
            cnt_d   = LOAD_STALL_CYCLES > 1 ? LOAD_RELOAD : cnt_q;
        end else begin
            state_d = ST_RUN;
        end
        if (rst) begin
            {pc_write, ifid_write, bubble_load, flush_branch, bubble_wait} = 5'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign state_o = rst ? 2'd0 : state_q;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_load_cnt_q, perf_load_cnt_d;
    logic [31:0] perf_branch_cnt_q, perf_branch_cnt_d;
    logic [31:0] perf_wait_cnt_q, perf_wait_cnt_d;
    always_comb begin
        perf_load_cnt_d   = perf_load_cnt_q + 32'(bubble_load && perf_load_cnt_q != '1);
        perf_branch_cnt_d = perf_branch_cnt_q + 32'(flush_branch && perf_branch_cnt_q != '1);
        perf_wait_cnt_d   = perf_wait_cnt_q + 32'(bubble_wait && perf_wait_cnt_q != '1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_cnt_q   <= '0;
            perf_branch_cnt_q <= '0;
            perf_wait_cnt_q   <= '0;
        end else begin
            perf_load_cnt_q   <= perf_load_cnt_d;
            perf_branch_cnt_q <= perf_branch_cnt_d;
            perf_wait_cnt_q   <= perf_wait_cnt_d;
        end
    end
    assign perf_load_cnt   = perf_load_cnt_q;
    assign perf_branch_cnt = perf_branch_cnt_q;
    assign perf_wait_cnt   = perf_wait_cnt_q;
`endif
    a_req_onehot: assert property (@(posedge clk) $onehot0({bubble_load, flush_branch, bubble_wait}));
    a_write_match: assert property (@(posedge clk) pc_write == ifid_write);
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench for hazard_stall_ctrl in two configurations.
module tb_hazard_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;
    logic       pw1, iw1, bl1, fb1, bw1, pw3, iw3, bl3, fb3, bw3;
    logic [1:0] so1, so3;
    int         checks = 0, errors = 0;
    logic [6:0] exp1_q[$], exp3_q[$];
    logic [1:0] m_st1 = '0, m_st3 = '0;
    logic [2:0] m_cnt1 = '0, m_cnt3 = '0;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] pl1, pb1, pw_1, pl3, pb3, pw_3;
    int          t_load = 0, t_branch = 0, t_wait = 0;
`endif
    always #5 clk = ~clk;
    hazard_stall_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_write(pw1), .ifid_write(iw1), .bubble_load(bl1),
        .flush_branch(fb1), .bubble_wait(bw1), .state_o(so1)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_load_cnt(pl1), .perf_branch_cnt(pb1), .perf_wait_cnt(pw_1)
`endif
    );
    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2)) dut3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_write(pw3), .ifid_write(iw3), .bubble_load(bl3),
        .flush_branch(fb3), .bubble_wait(bw3), .state_o(so3)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_load_cnt(pl3), .perf_branch_cnt(pb3), .perf_wait_cnt(pw_3)
`endif
    );
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask
    // Reference: outputs {pc_write, ifid_write, bubble_load, flush_branch, bubble_wait, state_o}
    task automatic model(input int lsc, input int bfc, input logic [1:0] st, input logic [2:0] cnt,
                         output logic [6:0] o, output logic [1:0] nst, output logic [2:0] ncnt);
        logic lu, pw, bl, fb, bw;
        lu = ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        pw = 1'b1; bl = 1'b0; fb = 1'b0; bw = 1'b0; nst = st; ncnt = cnt;
        case (st)
            2'd1: begin
                pw = 1'b0; bl = 1'b1;
                if (mem_busy) begin bl = 1'b0; bw = 1'b1; nst = 2'd3; end
                else if (cnt == 3'd0) nst = 2'd0;
                else ncnt = cnt - 3'd1;
            end
            2'd2: begin
                if (mem_busy) begin pw = 1'b0; bw = 1'b1; nst = 2'd3; end
                else begin
                    fb = 1'b1;
                    if (ex_branch_taken) ncnt = 3'(bfc - 2);
                    else if (cnt == 3'd0) nst = 2'd0;
                    else ncnt = cnt - 3'd1;
                end
            end
            default: begin
                if (mem_busy) begin pw = 1'b0; bw = 1'b1; nst = 2'd3; end
                else if (ex_branch_taken) begin
                    fb = 1'b1;
                    if (bfc > 1) begin nst = 2'd2; ncnt = 3'(bfc - 2); end else nst = 2'd0;
                end else if (lu) begin
                    pw = 1'b0; bl = 1'b1;
                    if (lsc > 1) begin nst = 2'd1; ncnt = 3'(lsc - 2); end else nst = 2'd0;
                end else nst = 2'd0;
            end
        endcase
        o = {pw, pw, bl, fb, bw, st};
        if (rst) begin o = '0; nst = 2'd0; ncnt = 3'd0; end
    endtask
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic [4:0] rd, input logic mr, input logic bt, input logic mb);
        logic [6:0] o;
        logic [1:0] ns1, ns3;
        logic [2:0] nc1, nc3;
        @(negedge clk);
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rd = rd;
        ex_mem_read = mr; ex_branch_taken = bt; mem_busy = mb;
        model(1, 1, m_st1, m_cnt1, o, ns1, nc1);
        exp1_q.push_back(o);
        model(3, 2, m_st3, m_cnt3, o, ns3, nc3);
        exp3_q.push_back(o);
        #2;
        o = exp1_q.pop_front();
        check_eq("cfg_1_1", {25'd0, pw1, iw1, bl1, fb1, bw1, so1}, {25'd0, o});
`ifdef HAZARD_PERF_CNT_EN
        if (r) begin t_load = 0; t_branch = 0; t_wait = 0; end
        else begin t_load += int'(o[4]); t_branch += int'(o[3]); t_wait += int'(o[2]); end
`endif
        o = exp3_q.pop_front();
        check_eq("cfg_3_2", {25'd0, pw3, iw3, bl3, fb3, bw3, so3}, {25'd0, o});
        @(posedge clk);
        m_st1 = ns1; m_cnt1 = nc1; m_st3 = ns3; m_cnt3 = nc3;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 5, 5, 1, 5, 1, 1, 1);
        idle(1);
        step(0, 5, 0, 0, 5, 1, 0, 0);
        idle(3);
        step(0, 0, 7, 0, 7, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0, 0);
        step(0, 3, 9, 1, 9, 1, 0, 0);
        idle(3);
        step(0, 5, 0, 0, 5, 1, 0, 0);
        step(0, 5, 0, 0, 5, 1, 0, 1);
        step(0, 5, 0, 0, 5, 1, 0, 0);
        idle(3);
        step(0, 5, 0, 0, 5, 1, 1, 0);
        idle(2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 5, 0, 0, 5, 1, 0, 0);
        step(1, 5, 0, 0, 5, 1, 0, 0);
        idle(2);
        step(0, 5, 0, 0, 5, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
`ifdef HAZARD_PERF_CNT_EN
        check_eq("perf_load", pl1, t_load);
        check_eq("perf_branch", pb1, t_branch);
        check_eq("perf_wait", pw_1, t_wait);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
